// File: rtl/commit_trace_buffer.sv
// Retire monitor: packs MEM/WB commit events into 54-bit trace records, queues them in a
// FIFO drained over valid/ready, and tracks cycle/instruction counts, halt and a watchdog.
module commit_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      pc,
    input  logic             reg_write,
    input  logic [3:0]       wr_reg,
    input  logic [15:0]      wr_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             hlt,
    output logic             trc_valid,
    input  logic             trc_ready,
    output logic [53:0]      trc_data,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic             done,
    output logic             timeout,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_HALT_PEND = 2'd1;
    localparam logic [1:0] ST_DONE      = 2'd2;
    localparam logic [1:0] ST_TIMEOUT   = 2'd3;

    localparam logic [1:0] TYPE_REG   = 2'b00;
    localparam logic [1:0] TYPE_LOAD  = 2'b01;
    localparam logic [1:0] TYPE_STORE = 2'b10;
    localparam logic [1:0] TYPE_HALT  = 2'b11;

    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WDOG_CNT = CNT_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic [53:0]      fifoMem [DEPTH];
    logic [AW-1:0]    wrPtrReg;
    logic [AW-1:0]    rdPtrReg;
    logic [AW:0]      countReg;
    logic [53:0]      headReg;
    logic [1:0]       stateReg;
    logic [1:0]       stateNext;
    logic [CNT_W-1:0] cycleCntReg;
    logic [CNT_W-1:0] instCntReg;
    logic [15:0]      haltPcReg;
    logic             doneReg;
    logic             timeoutReg;
    logic             overflowReg;

    logic             needReg;
    logic             needMem;
    logic [AW:0]      needCnt;
    logic [AW:0]      freeCnt;
    logic [1:0]       memType;
    logic [53:0]      regRec;
    logic [53:0]      memRec;
    logic [53:0]      haltRec;
    logic             push0;
    logic             push1;
    logic [53:0]      push0Data;
    logic [53:0]      push1Data;
    logic             setOverflow;
    logic             haltEnq;
    logic             pop;
    logic [AW:0]      pushCnt;
    logic [AW:0]      countNext;
    logic [AW-1:0]    rdPtrNext;
    logic [AW-1:0]    wrPtrPlus1;
    logic [CNT_W-1:0] cycleCntInc;

    // Event decode; a load and a store in the same cycle cancel each other out.
    assign needReg     = reg_write;
    assign needMem     = mem_read ^ mem_write;
    assign needCnt     = (AW+1)'(needReg) + (AW+1)'(needMem);
    assign freeCnt     = FULL_CNT - countReg;
    assign memType     = mem_write ? TYPE_STORE : TYPE_LOAD;
    assign regRec      = {TYPE_REG, wr_reg, pc, 16'h0000, wr_data};
    assign memRec      = {memType, 4'h0, pc, mem_addr, mem_data};
    assign haltRec     = {TYPE_HALT, 4'h0, haltPcReg, 16'h0000, instCntReg[15:0]};
    assign cycleCntInc = cycleCntReg + CNT_ONE;

    always_comb begin
        stateNext   = stateReg;
        push0       = 1'b0;
        push1       = 1'b0;
        push0Data   = regRec;
        push1Data   = memRec;
        setOverflow = 1'b0;
        haltEnq     = 1'b0;
        case (stateReg)
            ST_RUN: begin
                // Space is judged on start-of-cycle occupancy: a pop this cycle gives no credit.
                if (needCnt != '0) begin
                    if (freeCnt >= needCnt) begin
                        push0     = 1'b1;
                        push1     = needReg & needMem;
                        push0Data = needReg ? regRec : memRec;
                    end else begin
                        setOverflow = 1'b1;
                    end
                end
                if (hlt) begin
                    stateNext = ST_HALT_PEND;
                end else if (cycleCntInc == WDOG_CNT) begin
                    stateNext = ST_TIMEOUT;
                end
            end
            ST_HALT_PEND: begin
                if (countReg != FULL_CNT) begin
                    push0     = 1'b1;
                    push0Data = haltRec;
                    haltEnq   = 1'b1;
                    stateNext = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    assign pop        = (countReg != '0) && trc_ready;
    assign pushCnt    = (AW+1)'(push0) + (AW+1)'(push1);
    assign countNext  = countReg + pushCnt - (AW+1)'(pop);
    assign rdPtrNext  = rdPtrReg + AW'(pop);
    assign wrPtrPlus1 = wrPtrReg + AW'(1);

    // Storage array, no reset; up to two entries written per cycle.
    always_ff @(posedge clk) begin
        if (push0) begin
            fifoMem[wrPtrReg] <= push0Data;
        end
        if (push1) begin
            fifoMem[wrPtrPlus1] <= push1Data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg    <= ST_RUN;
            wrPtrReg    <= '0;
            rdPtrReg    <= '0;
            countReg    <= '0;
            headReg     <= '0;
            cycleCntReg <= '0;
            instCntReg  <= '0;
            haltPcReg   <= '0;
            doneReg     <= 1'b0;
            timeoutReg  <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            wrPtrReg <= wrPtrReg + AW'(push0) + AW'(push1);
            rdPtrReg <= rdPtrNext;
            countReg <= countNext;

            // Head is re-read every cycle; only push0 can ever land on the next head slot,
            // because the space check forbids writing over a live entry.
            if (countNext == '0) begin
                headReg <= '0;
            end else if (push0 && (rdPtrNext == wrPtrReg)) begin
                headReg <= push0Data;
            end else begin
                headReg <= fifoMem[rdPtrNext];
            end

            if (stateReg == ST_RUN) begin
                cycleCntReg <= cycleCntInc;
                if (hlt || reg_write || mem_write) begin
                    instCntReg <= instCntReg + CNT_ONE;
                end
                if (hlt) begin
                    haltPcReg <= pc;
                end
            end

            if (setOverflow) begin
                overflowReg <= 1'b1;
            end
            if (haltEnq) begin
                doneReg <= 1'b1;
            end
            if (stateReg == ST_RUN && stateNext == ST_TIMEOUT) begin
                timeoutReg <= 1'b1;
            end
        end
    end

    assign trc_valid   = (countReg != '0);
    assign trc_data    = headReg;
    assign cycle_count = cycleCntReg;
    assign inst_count  = instCntReg;
    assign done        = doneReg;
    assign timeout     = timeoutReg;
    assign overflow    = overflowReg;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: a long-watchdog instance for the data path and a
// second instance with WDOG_LIMIT=20 for the timeout behaviour.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = '0;
    logic        reg_write = 1'b0;
    logic [3:0]  wr_reg = '0;
    logic [15:0] wr_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_data = '0;
    logic        hlt = 1'b0;
    logic        trc_ready = 1'b0;

    logic        trc_valid, done, timeout, overflow;
    logic [53:0] trc_data;
    logic [31:0] cycle_count, inst_count;

    logic        wdValid, wdDone, wdTimeout, wdOverflow;
    logic [53:0] wdData;
    logic [31:0] wdCycle, wdInst;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(16), .CNT_W(32), .WDOG_LIMIT(1000)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write), .wr_reg(wr_reg),
        .wr_data(wr_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .hlt(hlt), .trc_valid(trc_valid), .trc_ready(trc_ready),
        .trc_data(trc_data), .cycle_count(cycle_count), .inst_count(inst_count),
        .done(done), .timeout(timeout), .overflow(overflow)
    );

    commit_trace_buffer #(.DEPTH(16), .CNT_W(32), .WDOG_LIMIT(20)) dutWd (
        .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write), .wr_reg(wr_reg),
        .wr_data(wr_data), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .hlt(hlt), .trc_valid(wdValid), .trc_ready(trc_ready),
        .trc_data(wdData), .cycle_count(wdCycle), .inst_count(wdInst),
        .done(wdDone), .timeout(wdTimeout), .overflow(wdOverflow)
    );

    function automatic logic [53:0] mkRec(input logic [1:0] t, input logic [3:0] r,
                                          input logic [15:0] p, input logic [15:0] a,
                                          input logic [15:0] d);
        return {t, r, p, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        pc = '0; reg_write = 1'b0; wr_reg = '0; wr_data = '0; mem_read = 1'b0;
        mem_write = 1'b0; mem_addr = '0; mem_data = '0; hlt = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearInputs();
        trc_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", trc_valid); end
        total++; if (trc_data !== 54'h0) begin bad++; $display("FAIL reset_data: got %h want 0", trc_data); end
        total++; if ({cycle_count, inst_count} !== 64'h0) begin bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_count, inst_count); end
        total++; if ({done, timeout, overflow} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {done, timeout, overflow}); end
    endtask

    task automatic test_reg_write();
        doReset();
        reg_write = 1'b1; wr_reg = 4'd3; wr_data = 16'h1234; pc = 16'h0010; trc_ready = 1'b1;
        tick();
        clearInputs();
        total++; if (trc_valid !== 1'b1) begin bad++; $display("FAIL reg_valid: got %b want 1", trc_valid); end
        total++; if (trc_data !== mkRec(2'b00, 4'd3, 16'h0010, 16'h0000, 16'h1234)) begin bad++; $display("FAIL reg_data: got %h want %h", trc_data, mkRec(2'b00, 4'd3, 16'h0010, 16'h0000, 16'h1234)); end
        total++; if (inst_count !== 32'd1 || cycle_count !== 32'd1) begin bad++; $display("FAIL reg_counts: got inst=%0d cyc=%0d want 1/1", inst_count, cycle_count); end
        tick();
        total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL reg_drained: got %b want 0", trc_valid); end
    endtask

    task automatic test_dual_push();
        doReset();
        reg_write = 1'b1; wr_reg = 4'd5; wr_data = 16'hBEEF; pc = 16'h0020;
        mem_read = 1'b1; mem_addr = 16'h0040; mem_data = 16'h00AA;
        tick();
        clearInputs();
        total++; if (trc_data !== mkRec(2'b00, 4'd5, 16'h0020, 16'h0000, 16'hBEEF)) begin bad++; $display("FAIL dual_first: got %h want REG record", trc_data); end
        total++; if (inst_count !== 32'd1) begin bad++; $display("FAIL dual_inst: got %0d want 1", inst_count); end
        trc_ready = 1'b1;
        tick();
        total++; if (trc_valid !== 1'b1 || trc_data !== mkRec(2'b01, 4'd0, 16'h0020, 16'h0040, 16'h00AA)) begin bad++; $display("FAIL dual_second: got v=%b %h want LOAD record", trc_valid, trc_data); end
        // Load and store together produce no memory record but still retire.
        mem_read = 1'b1; mem_write = 1'b1; mem_addr = 16'h0044; pc = 16'h0021;
        tick();
        clearInputs();
        total++; if (trc_valid !== 1'b0 || inst_count !== 32'd2) begin bad++; $display("FAIL dual_rw_both: got v=%b inst=%0d want 0/2", trc_valid, inst_count); end
    endtask

    task automatic test_back_to_back();
        doReset();
        trc_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            reg_write = 1'b1; wr_reg = 4'(i); wr_data = 16'hC000 + 16'(i); pc = 16'h0050 + 16'(i);
            tick();
            total++; if (trc_valid !== 1'b1 || trc_data !== mkRec(2'b00, 4'(i), 16'h0050 + 16'(i), 16'h0, 16'hC000 + 16'(i))) begin bad++; $display("FAIL b2b_%0d: got v=%b %h", i, trc_valid, trc_data); end
        end
        clearInputs();
        tick();
        total++; if (trc_valid !== 1'b0 || inst_count !== 32'd5) begin bad++; $display("FAIL b2b_end: got v=%b inst=%0d want 0/5", trc_valid, inst_count); end
    endtask

    task automatic test_overflow_and_reset();
        doReset();
        for (int i = 0; i < 17; i++) begin
            mem_write = 1'b1; mem_addr = 16'h0100 + 16'(i); mem_data = 16'hA000 + 16'(i); pc = 16'h0200 + 16'(i);
            tick();
            if (i == 15) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        clearInputs();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++; if (inst_count !== 32'd17) begin bad++; $display("FAIL ovf_inst: got %0d want 17", inst_count); end
        for (int k = 0; k < 9; k++) begin
            total++; if (trc_valid !== 1'b1 || trc_data !== mkRec(2'b10, 4'd0, 16'h0200 + 16'(k), 16'h0100 + 16'(k), 16'hA000 + 16'(k))) begin bad++; $display("FAIL ovf_order_%0d: got v=%b %h", k, trc_valid, trc_data); end
            trc_ready = (k < 8);
            tick();
        end
        trc_ready = 1'b0;
        // FIFO is half full here; a single reset cycle must clear everything.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (trc_valid !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL midreset_flags: got v=%b ovf=%b want 0/0", trc_valid, overflow); end
        total++; if (cycle_count !== 32'd0 || inst_count !== 32'd0) begin bad++; $display("FAIL midreset_counts: got %0d/%0d want 0/0", cycle_count, inst_count); end
        reg_write = 1'b1; wr_reg = 4'd7; wr_data = 16'h7777; pc = 16'h0077;
        tick();
        clearInputs();
        total++; if (trc_valid !== 1'b1 || trc_data !== mkRec(2'b00, 4'd7, 16'h0077, 16'h0, 16'h7777) || inst_count !== 32'd1) begin bad++; $display("FAIL midreset_run: got v=%b %h inst=%0d", trc_valid, trc_data, inst_count); end
    endtask

    task automatic test_partial_drop();
        doReset();
        for (int i = 0; i < 15; i++) begin
            mem_write = 1'b1; mem_addr = 16'(i); mem_data = 16'(i); pc = 16'h0300;
            tick();
        end
        // One slot free but two records needed: both are dropped.
        reg_write = 1'b1; wr_reg = 4'd9; wr_data = 16'h9999; mem_write = 1'b1; mem_addr = 16'hFFFF; mem_data = 16'h5555; pc = 16'h0300;
        tick();
        clearInputs();
        total++; if (overflow !== 1'b1 || inst_count !== 32'd16) begin bad++; $display("FAIL drop2_ovf: got ovf=%b inst=%0d want 1/16", overflow, inst_count); end
        reg_write = 1'b1; wr_reg = 4'd10; wr_data = 16'hAAAA; pc = 16'h0301;
        tick();
        clearInputs();
        trc_ready = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        total++; if (trc_valid !== 1'b1 || trc_data !== mkRec(2'b00, 4'd10, 16'h0301, 16'h0, 16'hAAAA)) begin bad++; $display("FAIL drop2_last: got v=%b %h", trc_valid, trc_data); end
        tick();
        total++; if (trc_valid !== 1'b0) begin bad++; $display("FAIL drop2_empty: got %b want 0", trc_valid); end
    endtask

    task automatic test_halt();
        logic [53:0] exp;
        doReset();
        for (int i = 0; i < 16; i++) begin
            if (i < 7) begin
                reg_write = 1'b1; mem_read = 1'b0; wr_reg = 4'(i + 1); wr_data = 16'h0100 + 16'(i); pc = 16'h0010 + 16'(i);
            end else begin
                reg_write = 1'b0; mem_read = 1'b1; mem_addr = 16'h0400 + 16'(i - 7); mem_data = 16'h0500 + 16'(i - 7); pc = 16'h0030 + 16'(i - 7);
            end
            tick();
        end
        clearInputs();
        hlt = 1'b1; pc = 16'h0100;
        tick();
        clearInputs();
        total++; if (inst_count !== 32'd8 || cycle_count !== 32'd17 || done !== 1'b0) begin bad++; $display("FAIL halt_entry: got inst=%0d cyc=%0d done=%b want 8/17/0", inst_count, cycle_count, done); end
        reg_write = 1'b1; mem_write = 1'b1; wr_reg = 4'd15;
        for (int k = 0; k < 3; k++) tick();
        clearInputs();
        total++; if (inst_count !== 32'd8 || cycle_count !== 32'd17 || done !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL halt_frozen: got inst=%0d cyc=%0d done=%b ovf=%b", inst_count, cycle_count, done, overflow); end
        trc_ready = 1'b1;
        tick();
        trc_ready = 1'b0;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL halt_early_done: got %b want 0", done); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL halt_done: got %b want 1", done); end
        trc_ready = 1'b1;
        for (int k = 1; k < 17; k++) begin
            if (k < 7) exp = mkRec(2'b00, 4'(k + 1), 16'h0010 + 16'(k), 16'h0, 16'h0100 + 16'(k));
            else if (k < 16) exp = mkRec(2'b01, 4'd0, 16'h0030 + 16'(k - 7), 16'h0400 + 16'(k - 7), 16'h0500 + 16'(k - 7));
            else exp = mkRec(2'b11, 4'd0, 16'h0100, 16'h0000, 16'h0008);
            total++; if (trc_valid !== 1'b1 || trc_data !== exp) begin bad++; $display("FAIL halt_drain_%0d: got v=%b %h want %h", k, trc_valid, trc_data, exp); end
            tick();
        end
        total++; if (trc_valid !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL halt_final: got v=%b done=%b want 0/1", trc_valid, done); end
    endtask

    task automatic test_timeout();
        doReset();
        for (int k = 0; k < 19; k++) tick();
        total++; if (wdCycle !== 32'd19 || wdTimeout !== 1'b0) begin bad++; $display("FAIL wd_before: got cyc=%0d to=%b want 19/0", wdCycle, wdTimeout); end
        tick();
        total++; if (wdCycle !== 32'd20 || wdTimeout !== 1'b1) begin bad++; $display("FAIL wd_fire: got cyc=%0d to=%b want 20/1", wdCycle, wdTimeout); end
        reg_write = 1'b1; wr_reg = 4'd2; wr_data = 16'h2222; mem_write = 1'b1;
        tick();
        tick();
        clearInputs();
        total++; if (wdValid !== 1'b0 || wdInst !== 32'd0 || wdCycle !== 32'd20 || wdTimeout !== 1'b1) begin bad++; $display("FAIL wd_ignore: got v=%b inst=%0d cyc=%0d to=%b", wdValid, wdInst, wdCycle, wdTimeout); end
        total++; if (timeout !== 1'b0 || inst_count !== 32'd2) begin bad++; $display("FAIL wd_main: got to=%b inst=%0d want 0/2", timeout, inst_count); end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_dual_push();
        test_back_to_back();
        test_overflow_and_reset();
        test_partial_drop();
        test_halt();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
